// File: rtl/mosquito_swarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mosquito_swarm_ctrl
//  Description : Holds position, direction, alive flag and respawn countdown
//                of every enemy mosquito. Moves them once per frame, kills
//                them on bullet hits, respawns them at LFSR-derived positions
//                and keeps a saturating kill counter. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mosquito_swarm_ctrl #(
    parameter int MOSQUITO_COUNT = 4,
    parameter int SPRITE_SIZE    = 32,
    parameter int SCREEN_W       = 640,
    parameter int Y_MIN          = 32,
    parameter int Y_MAX          = 240,
    parameter int STEP_X         = 2,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [MOSQUITO_COUNT-1:0]    hit_mask,
    output logic [10*MOSQUITO_COUNT-1:0] mosquito_x_flat,
    output logic [10*MOSQUITO_COUNT-1:0] mosquito_y_flat,
    output logic [MOSQUITO_COUNT-1:0]    mosquito_alive,
    output logic                         kill_pulse,
    output logic [7:0]                   kill_count
);

    // Rightmost x at which a sprite is still fully on screen
    localparam logic [9:0]  c_X_MAX      = 10'(SCREEN_W - SPRITE_SIZE);
    localparam logic [10:0] c_STEP_X_W   = 11'(STEP_X);
    localparam logic [9:0]  c_STEP_X     = 10'(STEP_X);
    localparam logic [9:0]  c_Y_MIN      = 10'(Y_MIN);
    localparam logic [9:0]  c_Y_MAX      = 10'(Y_MAX);
    localparam logic [7:0]  c_RESPAWN    = 8'(RESPAWN_FRAMES);
    localparam logic [9:0]  c_LFSR_SEED  = 10'h2A5;

    logic [9:0]                r_lfsr;
    logic [MOSQUITO_COUNT-1:0] w_kill;
    logic [2:0]                w_kill_num;
    logic [8:0]                w_kill_sum;
    logic                      r_kill_pulse;
    logic [7:0]                r_kill_count;

    // Fibonacci LFSR (x^10 + x^7 + 1), stepped only by frame_tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (frame_tick) begin
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
        end
    end

    // Number of live mosquitoes hit this cycle and the unsaturated new total
    always_comb begin
        w_kill_num = '0;
        for (int k = 0; k < MOSQUITO_COUNT; k++) begin
            w_kill_num = w_kill_num + {2'b00, w_kill[k]};
        end
        w_kill_sum = {1'b0, r_kill_count} + {6'd0, w_kill_num};
    end

    // Kill pulse and saturating kill counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill_pulse <= 1'b0;
            r_kill_count <= 8'd0;
        end else begin
            r_kill_pulse <= (w_kill_num != 3'd0);
            r_kill_count <= w_kill_sum[8] ? 8'hFF : w_kill_sum[7:0];
        end
    end

    assign kill_pulse = r_kill_pulse;
    assign kill_count = r_kill_count;

    generate
        for (genvar gi = 0; gi < MOSQUITO_COUNT; gi++) begin : g_mosq
            localparam logic [9:0] c_X_INIT = 10'(64 + 128 * gi);
            localparam int         c_ROT    = 2 * gi;

            logic [9:0] r_x;
            logic [9:0] r_y;
            logic       r_dx;
            logic       r_dy;
            logic       r_alive;
            logic [7:0] r_cnt;
            logic [9:0] w_rnd;
            logic [9:0] w_x_next;
            logic [9:0] w_y_next;
            logic       w_dx_next;
            logic       w_dy_next;

            // Each mosquito sees a differently rotated copy of the LFSR
            assign w_rnd = (r_lfsr << c_ROT) | (r_lfsr >> (10 - c_ROT));

            assign w_kill[gi] = hit_mask[gi] & r_alive;

            // Next position: bounce off the screen edges and the flight band
            always_comb begin
                w_x_next  = r_x;
                w_dx_next = r_dx;
                w_y_next  = r_y;
                w_dy_next = r_dy;
                if (!r_dx) begin
                    if (({1'b0, r_x} + c_STEP_X_W) > {1'b0, c_X_MAX}) begin
                        w_x_next  = c_X_MAX;
                        w_dx_next = 1'b1;
                    end else begin
                        w_x_next = r_x + c_STEP_X;
                    end
                end else begin
                    if (r_x < c_STEP_X) begin
                        w_x_next  = 10'd0;
                        w_dx_next = 1'b0;
                    end else begin
                        w_x_next = r_x - c_STEP_X;
                    end
                end
                if (!r_dy) begin
                    if (r_y >= c_Y_MAX) begin
                        w_dy_next = 1'b1;
                    end else begin
                        w_y_next = r_y + 10'd1;
                    end
                end else begin
                    if (r_y <= c_Y_MIN) begin
                        w_dy_next = 1'b0;
                    end else begin
                        w_y_next = r_y - 10'd1;
                    end
                end
            end

            // Per-mosquito state: a hit beats a frame tick in the same cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_x     <= c_X_INIT;
                    r_y     <= c_Y_MIN;
                    r_dx    <= 1'b0;
                    r_dy    <= 1'b0;
                    r_alive <= 1'b1;
                    r_cnt   <= 8'd0;
                end else if (w_kill[gi]) begin
                    r_alive <= 1'b0;
                    r_cnt   <= c_RESPAWN;
                end else if (frame_tick) begin
                    if (r_alive) begin
                        r_x  <= w_x_next;
                        r_y  <= w_y_next;
                        r_dx <= w_dx_next;
                        r_dy <= w_dy_next;
                    end else if (r_cnt > 8'd1) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_cnt == 8'd1) begin
                        r_alive <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_x     <= {1'b0, w_rnd[8:0]};
                        r_y     <= c_Y_MIN + {4'd0, w_rnd[5:0]};
                        r_dx    <= w_rnd[9];
                        r_dy    <= 1'b0;
                    end
                end
            end

            assign mosquito_x_flat[gi*10 +: 10] = r_x;
            assign mosquito_y_flat[gi*10 +: 10] = r_y;
            assign mosquito_alive[gi]           = r_alive;
        end
    endgenerate

endmodule
`default_nettype wire
